phase_scheduler: RTL

PHASE_SCHEDULER -- requirements
Module: phase_scheduler

---
 rtl/phase_scheduler.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/phase_scheduler.sv
// Timestep sequencer: runs a conv phase then a pool phase, owning the BRAM arbiter
// phase select, with quiet-bus drain windows, RUN-state timeout and abort.
module phase_scheduler #(
  parameter int unsigned DRAIN_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned STEP_BITS      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 conv_done,
  input  logic                 pool_done,
  input  logic                 arb_active,
  output logic                 conv_start,
  output logic                 pool_start,
  output logic                 conv_or_pool,
  output logic                 enable,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [2:0]           phase,
  output logic [STEP_BITS-1:0] step_count
);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StConvStart = 3'd1,
    StConvRun   = 3'd2,
    StConvDrain = 3'd3,
    StPoolStart = 3'd4,
    StPoolRun   = 3'd5,
    StPoolDrain = 3'd6,
    StDone      = 3'd7
  } state_e;

  localparam logic [7:0]           DrainLast   = 8'(DRAIN_CYCLES - 1);
  localparam logic [15:0]          TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [STEP_BITS-1:0] StepOne     = STEP_BITS'(1);

  state_e                state_q, state_d;
  logic [7:0]            drain_cnt_q, drain_cnt_d;
  logic [15:0]           tmo_cnt_q, tmo_cnt_d;
  logic                  timeout_q, timeout_d;
  logic [STEP_BITS-1:0]  step_q, step_d;

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    timeout_d   = timeout_q;
    step_d      = step_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StConvStart;
          timeout_d = 1'b0;
        end
      end
      StConvStart: begin
        state_d   = StConvRun;
        tmo_cnt_d = '0;
      end
      StConvRun: begin
        // done beats a coincident timeout
        if (conv_done) begin
          state_d     = StConvDrain;
          drain_cnt_d = '0;
        end else if (tmo_cnt_q == TimeoutLast) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end
      StConvDrain: begin
        if (arb_active) begin
          drain_cnt_d = '0;
        end else if (drain_cnt_q == DrainLast) begin
          state_d = StPoolStart;
        end else begin
          drain_cnt_d = drain_cnt_q + 8'd1;
        end
      end
      StPoolStart: begin
        state_d   = StPoolRun;
        tmo_cnt_d = '0;
      end
      StPoolRun: begin
        if (pool_done) begin
          state_d     = StPoolDrain;
          drain_cnt_d = '0;
        end else if (tmo_cnt_q == TimeoutLast) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end
      StPoolDrain: begin
        if (arb_active) begin
          drain_cnt_d = '0;
        end else if (drain_cnt_q == DrainLast) begin
          state_d = StDone;
        end else begin
          drain_cnt_d = drain_cnt_q + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        step_d  = step_q + StepOne;
      end
      default: state_d = StIdle;
    endcase
    // abort overrides everything, including a start in IDLE and the DONE-cycle increment
    if (abort) begin
      state_d   = StIdle;
      timeout_d = timeout_q;
      step_d    = step_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      drain_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      timeout_q   <= 1'b0;
      step_q      <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      timeout_q   <= timeout_d;
      step_q      <= step_d;
    end
  end

  always_comb begin
    conv_start   = (state_q == StConvStart);
    pool_start   = (state_q == StPoolStart);
    conv_or_pool = !((state_q == StPoolStart) || (state_q == StPoolRun) ||
                     (state_q == StPoolDrain));
    enable       = (state_q != StIdle) && (state_q != StDone);
    busy         = (state_q != StIdle);
    done         = (state_q == StDone);
    timeout      = timeout_q;
    phase        = state_q;
    step_count   = step_q;
  end

endmodule
